// File: rtl/display_source_scheduler.sv
// Round-robin scheduler that shares one seven-segment driver among
// several counter sources, with blanking gaps and a manual step mode.
module display_source_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int NUM_SEGMENTS = 4,
  parameter int DWELL_CLKS   = 200_000_000,
  parameter int BLANK_CLKS   = 1_000_000,
  localparam int SW = $clog2(NUM_SRC)
) (
  input  logic clk,
  input  logic CPU_RESETN,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
  input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0] src_digit_point,
  input  logic [NUM_SRC-1:0] src_valid,
  input  logic btn_next,
  input  logic btn_mode,
  output logic [NUM_SEGMENTS-1:0][3:0] encoded,
  output logic [NUM_SEGMENTS-1:0] digit_point,
  output logic blank,
  output logic [SW-1:0] sel,
  output logic [NUM_SRC-1:0] sel_onehot,
  output logic manual
);

  localparam int MAXC = (DWELL_CLKS > BLANK_CLKS) ?
                        DWELL_CLKS : BLANK_CLKS;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL_CLKS - 1);
  localparam logic [CW-1:0] GAP_END = CW'(BLANK_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0] sel_d, low_idx, nxt_idx;
  logic [CW-1:0] dwell_cnt, dwell_d;
  logic [CW-1:0] gap_cnt, gap_d;
  logic manual_d, other_valid, step;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) low_idx = SW'(i);
    end
  end

  // Closest valid source after sel, wrapping, excluding sel itself.
  always_comb begin
    int idx;
    nxt_idx = sel;
    other_valid = 1'b0;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = (int'(sel) + k) % NUM_SRC;
      if (src_valid[SW'(idx)]) begin
        nxt_idx = SW'(idx);
        other_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel;
    dwell_d  = dwell_cnt;
    gap_d    = gap_cnt;
    manual_d = manual ^ btn_mode;
    step = manual ? btn_next : (dwell_cnt == DWELL_END);
    unique case (state_q)
      IDLE: begin
        if (|src_valid) begin
          state_d = SHOW;
          sel_d   = low_idx;
          dwell_d = '0;
        end
      end
      SHOW: begin
        if (!src_valid[sel]) begin
          state_d = BLANK;
          gap_d   = '0;
        end else if (btn_mode) begin
          if (manual) dwell_d = '0;
        end else if (step) begin
          dwell_d = '0;
          if (other_valid) begin
            state_d = BLANK;
            gap_d   = '0;
          end
        end else if (!manual) begin
          dwell_d = dwell_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (gap_cnt == GAP_END) begin
          gap_d   = '0;
          dwell_d = '0;
          if (other_valid) begin
            state_d = SHOW;
            sel_d   = nxt_idx;
          end else if (src_valid[sel]) begin
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= IDLE;
      sel         <= '0;
      manual      <= 1'b0;
      dwell_cnt   <= '0;
      gap_cnt     <= '0;
      encoded     <= '0;
      digit_point <= '0;
      blank       <= 1'b1;
      sel_onehot  <= '0;
    end else begin
      state_q   <= state_d;
      sel       <= sel_d;
      manual    <= manual_d;
      dwell_cnt <= dwell_d;
      gap_cnt   <= gap_d;
      blank     <= (state_d != SHOW);
      if (state_d == SHOW) begin
        encoded     <= src_encoded[sel_d];
        digit_point <= src_digit_point[sel_d];
        sel_onehot  <= NUM_SRC'(1) << sel_d;
      end else begin
        encoded     <= '0;
        digit_point <= '0;
        sel_onehot  <= '0;
      end
    end
  end

endmodule
